mode_arbiter: RTL and testbench
===============================

Name: mode_arbiter

Overview:
- Owns the shared speaker and LED resources and hands them between the three player sources: free piano, auto-play and learning.
- Debounces mode_select and mutes the speaker for a guard interval on every mode change, so no clicks or partial notes leak through.
- Gives each sub-controller a one-hot enable and a one-cycle restart pulse, so the newly selected mode always starts from a clean state.
- Sits between the player sub-modules and the top-level speaker/led pins, replacing the top level's combinational output muxes.

Parameters:
- DEBOUNCE_CYCLES, 2000000: cycles a new mode_select value must stay stable before a switch (20 ms at 100 MHz).
- MUTE_CYCLES, 1000000: cycles the speaker and LEDs are forced low during a handoff (10 ms).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mode_select  in  3  raw switch value; 0=FREE, 1=AUTO, 2=LEARN, 3..7 map to FREE.
- src_speaker  in  3  speaker bit per source; [0]=FREE, [1]=AUTO, [2]=LEARN.
- led_free  in  7  LED pattern from the FREE source.
- led_auto  in  7  LED pattern from the AUTO source.
- led_learn  in  7  LED pattern from the LEARN source.
- speaker  out  1  registered, arbitrated speaker output.
- led  out  7  registered, arbitrated LED output.
- mode_en  out  3  one-hot enable for the active source.
- mode_rst  out  3  one-cycle, active-high restart pulse for the incoming source.
- current_mode  out  2  active mode code (0, 1 or 2).
- switching  out  1  high during MUTE and RESTART.

Behaviour:
- Reset (reset=0, asynchronous) sets these values:
  - state=RUN, current_mode=0, mode_en=3'b001, mode_rst=0.
  - speaker=0, led=0, switching=0.
  - counters=0, synchroniser flops=0.
- mode_select passes through a 2-flop synchroniser, then is decoded to target (2-bit); codes 3..7 decode to 0.
- States:
  - RUN: if target != current_mode, latch cand<=target, cnt<=0, go to DEBOUNCE.
  - DEBOUNCE: the speaker and LEDs still follow current_mode.
    - If target == current_mode, return to RUN; this is a glitch and is ignored.
    - Else if target != cand, set cand<=target and cnt<=0; stay in DEBOUNCE.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to MUTE with cnt<=0 and mode_en<=0.
    - Otherwise cnt++.
  - MUTE: mode_en=0, speaker=0, led=0, switching=1; mode_select is ignored. When cnt == MUTE_CYCLES-1, set current_mode<=cand and go to RESTART.
  - RESTART (exactly 1 cycle): mode_rst[current_mode]=1, speaker=0, led=0, switching=1. Next cycle: RUN with mode_en<=one-hot(current_mode), mode_rst<=0.
- In RUN/DEBOUNCE, speaker<=src_speaker[current_mode] and led<=the selected led_* bus, so they have 1 cycle of latency. In MUTE/RESTART both are driven 0.
- A mode_select change that arrives during MUTE or RESTART is handled only after returning to RUN, as a fresh debounce.
- Counter widths are $clog2 of the max parameter value; counters never wrap within a state.
- Asserting reset mid-handoff aborts it immediately and returns to FREE.
- Both parameters must be at least 1; DEBOUNCE_CYCLES=1 means a switch after one stable cycle.

Test Plan (DEBOUNCE_CYCLES=8, MUTE_CYCLES=4):
- Reset, then mode_select=0, src_speaker=3'b001, led_free=7'h55. Required: mode_en=001, switching=0; from the second cycle speaker=1 and led=7'h55.
- mode_select 0→1 held. Required, counting cycles after the synchronised change (T=0):
  - DEBOUNCE from T+1, speaker still follows src_speaker[0].
  - MUTE starts at T+9: mode_en=000, speaker=0 for 4 cycles.
  - RESTART at T+13: mode_rst=010 for exactly 1 cycle.
  - At T+14: mode_en=010, current_mode=1, and speaker follows src_speaker[1] from T+15.
- mode_select 0→2 for 5 cycles, then back to 0. Required: no MUTE, mode_en stays 001, switching never asserts.
- mode_select 0→1 for 5 cycles, then →2 held. Required: the debounce restarts on the change; the switch lands on mode 2 with mode_rst=100, never on mode 1.
- mode_select=5 from FREE. Required: no switch. Then from LEARN set 5. Required: a switch to FREE with mode_rst=001.
- Pull reset low during MUTE. Required: asynchronous return to current_mode=0, mode_en=001, speaker=0, switching=0 with no mode_rst pulse.

Source files
------------

// File: rtl/mode_arbiter.sv
// mode_arbiter: hands the speaker and LEDs between free/auto/learn sources
// with a debounced select, a muted handoff and a one-cycle restart pulse.
module mode_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned MUTE_CYCLES     = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_select,
  input  logic [2:0] src_speaker,
  input  logic [6:0] led_free,
  input  logic [6:0] led_auto,
  input  logic [6:0] led_learn,
  output logic       speaker,
  output logic [6:0] led,
  output logic [2:0] mode_en,
  output logic [2:0] mode_rst,
  output logic [1:0] current_mode,
  output logic       switching
);

  localparam int unsigned MAXC =
    (DEBOUNCE_CYCLES > MUTE_CYCLES) ? DEBOUNCE_CYCLES : MUTE_CYCLES;
  localparam int unsigned CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MU_LAST = CW'(MUTE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN,
    DEBOUNCE,
    MUTE,
    RESTART
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  en_q, en_d;
  logic [2:0]  rst_q, rst_d;
  logic        spk_q, spk_d;
  logic [6:0]  led_q, led_d;
  logic        sw_q, sw_d;
  logic [1:0]  target;
  logic        live;
  logic        src_spk;
  logic [6:0]  src_led;

  function automatic logic [2:0] onehot(input logic [1:0] m);
    return 3'b001 << m;
  endfunction

  always_comb begin
    target  = (sync2_q > 3'd2) ? 2'd0 : sync2_q[1:0];
    state_d = state_q;
    cand_d  = cand_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rst_d   = '0;
    unique case (state_q)
      RUN: begin
        if (target != cur_q) begin
          cand_d  = target;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (target == cur_q) begin
          state_d = RUN;
        end else if (target != cand_q) begin
          cand_d = target;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = MUTE;
          cnt_d   = '0;
          en_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MUTE: begin
        if (cnt_q == MU_LAST) begin
          cur_d   = cand_q;
          rst_d   = onehot(cand_q);
          cnt_d   = '0;
          state_d = RESTART;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESTART: begin
        state_d = RUN;
        en_d    = onehot(cur_q);
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    case (cur_q)
      2'd1: begin
        src_spk = src_speaker[1];
        src_led = led_auto;
      end
      2'd2: begin
        src_spk = src_speaker[2];
        src_led = led_learn;
      end
      default: begin
        src_spk = src_speaker[0];
        src_led = led_free;
      end
    endcase
    // outputs go quiet on the same edge the handoff begins
    live  = (state_q == RUN || state_q == DEBOUNCE) &&
            (state_d == RUN || state_d == DEBOUNCE);
    spk_d = live ? src_spk : 1'b0;
    led_d = live ? src_led : 7'd0;
    sw_d  = (state_d == MUTE) || (state_d == RESTART);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 3'b001;
      rst_q   <= '0;
      spk_q   <= 1'b0;
      led_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= mode_select;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      spk_q   <= spk_d;
      led_q   <= led_d;
      sw_q    <= sw_d;
    end
  end

  assign speaker      = spk_q;
  assign led          = led_q;
  assign mode_en      = en_q;
  assign mode_rst     = rst_q;
  assign current_mode = cur_q;
  assign switching    = sw_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// tb_mode_arbiter: randomized scoreboard bench for mode_arbiter
// against a run-length/handoff-timer reference model.
module tb_mode_arbiter;

  localparam int D = 8;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode_select = '0;
  logic [2:0] src_speaker = '0;
  logic [6:0] led_free = '0;
  logic [6:0] led_auto = '0;
  logic [6:0] led_learn = '0;
  logic       speaker;
  logic [6:0] led;
  logic [2:0] mode_en;
  logic [2:0] mode_rst;
  logic [1:0] current_mode;
  logic       switching;

  mode_arbiter #(
    .DEBOUNCE_CYCLES(D),
    .MUTE_CYCLES(M)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_select(mode_select),
    .src_speaker(src_speaker),
    .led_free(led_free),
    .led_auto(led_auto),
    .led_learn(led_learn),
    .speaker(speaker),
    .led(led),
    .mode_en(mode_en),
    .mode_rst(mode_rst),
    .current_mode(current_mode),
    .switching(switching)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       spk;
    logic [6:0] led;
    logic [2:0] en;
    logic [2:0] rst;
    logic [1:0] cm;
    logic       sw;
  } out_t;

  out_t exp_q[$];
  logic [2:0] rst_seen[$];
  int   sw_cnt;
  int   compared = 0;
  int   mismatched = 0;
  int   cycle_no = 0;
  bit   in_rst = 1'b1;
  bit   rand_data = 1'b0;

  // reference model: select history, run length of a stable new target,
  // and cycles left in the handoff (mute + restart)
  int m_mode, m_cand, m_run, m_hold, m_s1, m_s2;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @%0d: got %0h want %0h", name, cycle_no, act, req);
    end
  endtask

  function automatic logic [2:0] oh(input int m);
    return 3'(1 << m);
  endfunction

  function automatic logic [6:0] led_of(input int m);
    if (m == 1) return led_auto;
    if (m == 2) return led_learn;
    return led_free;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cand = 0;
    m_run  = 0;
    m_hold = 0;
    m_s1   = 0;
    m_s2   = 0;
  endtask

  task automatic model_step();
    int   tgt;
    out_t o;
    tgt = (m_s2 > 2) ? 0 : m_s2;
    o = '0;
    if (m_hold == 0) begin
      if (tgt == m_mode) m_run = 0;
      else if (m_run > 0 && tgt == m_cand) m_run++;
      else begin
        m_cand = tgt;
        m_run  = 1;
      end
      if (m_run == D + 1) begin
        m_run  = 0;
        m_hold = M + 1;
        o.sw   = 1'b1;
      end else begin
        o.en  = oh(m_mode);
        o.spk = src_speaker[m_mode];
        o.led = led_of(m_mode);
      end
    end else begin
      m_hold--;
      if (m_hold == 1) begin
        m_mode = m_cand;
        o.rst  = oh(m_mode);
        o.sw   = 1'b1;
      end else if (m_hold == 0) begin
        o.en = oh(m_mode);
      end else begin
        o.sw = 1'b1;
      end
    end
    o.cm = 2'(m_mode);
    m_s2 = m_s1;
    m_s1 = int'(mode_select);
    exp_q.push_back(o);
  endtask

  out_t mon_e, mon_a;

  always @(negedge clk) begin
    cycle_no++;
    if (!in_rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {speaker, led, mode_en, mode_rst, current_mode, switching};
      check("outputs", 32'(mon_a), 32'(mon_e));
      if (mode_rst != 3'b000) rst_seen.push_back(mode_rst);
      if (switching) sw_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!in_rst) model_step();
      @(negedge clk);
      #1;
      if (rand_data) begin
        src_speaker = 3'($urandom);
        led_free    = 7'($urandom);
        led_auto    = 7'($urandom);
        led_learn   = 7'($urandom);
      end
    end
  endtask

  task automatic clear_logs();
    rst_seen.delete();
    sw_cnt = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    in_rst = 1'b0;
  endtask

  initial begin
    out_t rst_val;
    rst_val = '{spk: 1'b0, led: 7'd0, en: 3'b001, rst: 3'b000,
                cm: 2'd0, sw: 1'b0};
    clear_logs();
    model_reset();
    src_speaker = 3'b001;
    led_free    = 7'h55;
    #1 reset = 1'b0;
    #2;
    check("reset_state",
          32'({speaker, led, mode_en, mode_rst, current_mode, switching}),
          32'(rst_val));
    release_reset();

    cyc(1);
    cyc(1);
    check("free_speaker", 32'(speaker), 32'd1);
    check("free_led", 32'(led), 32'h55);
    check("free_en", 32'(mode_en), 32'b001);
    rand_data = 1'b1;

    clear_logs();
    mode_select = 3'd1;
    cyc(30);
    check("to_auto_rst_cnt", 32'(rst_seen.size()), 32'd1);
    if (rst_seen.size() > 0) check("to_auto_rst", 32'(rst_seen[0]), 32'b010);
    check("to_auto_sw_len", 32'(sw_cnt), 32'(M + 1));
    check("to_auto_mode", 32'(current_mode), 32'd1);
    check("to_auto_en", 32'(mode_en), 32'b010);

    mode_select = 3'd0;
    cyc(30);
    clear_logs();
    mode_select = 3'd2;
    cyc(5);
    mode_select = 3'd0;
    cyc(20);
    check("glitch_sw", 32'(sw_cnt), 32'd0);
    check("glitch_rst", 32'(rst_seen.size()), 32'd0);
    check("glitch_en", 32'(mode_en), 32'b001);

    clear_logs();
    mode_select = 3'd1;
    cyc(5);
    mode_select = 3'd2;
    cyc(30);
    check("retarget_rst_cnt", 32'(rst_seen.size()), 32'd1);
    if (rst_seen.size() > 0) check("retarget_rst", 32'(rst_seen[0]), 32'b100);
    check("retarget_mode", 32'(current_mode), 32'd2);

    mode_select = 3'd0;
    cyc(30);
    clear_logs();
    mode_select = 3'd5;
    cyc(30);
    check("sel5_free_sw", 32'(sw_cnt), 32'd0);
    mode_select = 3'd2;
    cyc(30);
    clear_logs();
    mode_select = 3'd5;
    cyc(30);
    check("sel5_learn_rst_cnt", 32'(rst_seen.size()), 32'd1);
    if (rst_seen.size() > 0) check("sel5_learn_rst", 32'(rst_seen[0]), 32'b001);
    check("sel5_learn_mode", 32'(current_mode), 32'd0);

    mode_select = 3'd1;
    for (int i = 0; i < 40 && m_hold != M; i++) cyc(1);
    check("mute_reach", 32'(m_hold), 32'(M));
    check("pre_rst_sw", 32'(switching), 32'd1);
    #2;
    in_rst = 1'b1;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("async_rst",
          32'({speaker, led, mode_en, mode_rst, current_mode, switching}),
          32'(rst_val));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_pulse", 32'(mode_rst), 32'd0);
    end
    release_reset();
    cyc(30);

    for (int s = 0; s < 60; s++) begin
      mode_select = 3'($urandom_range(0, 7));
      cyc($urandom_range(1, 20));
    end
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
